clint_responder: RTL and testbench

- Memory-mapped CLINT target that answers CPU data-bus requests in the clint window at 0x2000000–0x200BFFF.
- Holds the machine software-interrupt bit (msip), the 64-bit mtime counter and the 64-bit mtimecmp compare register.
- mtime advances at the RTC rate, derived from the core clock by an internal divider.
- Drives the msip/mtip interrupt lines into the core CSR unit.

---
 rtl/clint_responder.sv | 113 +++++++++++
 tb/tb_clint_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_responder.sv
// CLINT bus target: msip, mtime and mtimecmp registers, with the msip/mtip interrupt lines.
// Every request gets a single-cycle response on the next clock and there is no backpressure.
module clint_responder #(
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
  parameter int unsigned clk_divider_rtc = 30516
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  localparam logic [31:0] OffMsip    = 32'h0000_0000;
  localparam logic [31:0] OffCmpLo   = 32'h0000_4000;
  localparam logic [31:0] OffCmpHi   = 32'h0000_4004;
  localparam logic [31:0] OffMtimeLo = 32'h0000_BFF8;
  localparam logic [31:0] OffMtimeHi = 32'h0000_BFFC;

  logic [31:0] div_q, div_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q, mtip_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;

  logic        tick;
  logic        in_win, acc, wr;
  logic [31:0] off_w;
  logic [31:0] wmask;
  logic [63:0] mtime_tick;

  always_comb begin
    tick       = (div_q == clk_divider_rtc);
    div_d      = tick ? 32'd0 : div_q + 32'd1;
    mtime_tick = tick ? mtime_q + 64'd1 : mtime_q;

    // Word offset; addr[1:0] are ignored by masking before the subtract.
    off_w  = (clint_addr & ~32'h3) - clint_base_addr;
    in_win = (clint_addr >= clint_base_addr) && (clint_addr < clint_top_addr);
    acc    = clint_valid && !clint_instr && in_win;
    wr     = acc && (clint_wstrb != 4'b0000);
    wmask  = {{8{clint_wstrb[3]}}, {8{clint_wstrb[2]}},
              {8{clint_wstrb[1]}}, {8{clint_wstrb[0]}}};

    // Reads see the state registered before this edge, so mtime reads are pre-tick.
    rdata_d = 32'd0;
    if (acc) begin
      case (off_w)
        OffMsip:    rdata_d = {31'd0, msip_q};
        OffCmpLo:   rdata_d = mtimecmp_q[31:0];
        OffCmpHi:   rdata_d = mtimecmp_q[63:32];
        OffMtimeLo: rdata_d = mtime_q[31:0];
        OffMtimeHi: rdata_d = mtime_q[63:32];
        default:    rdata_d = 32'd0;
      endcase
    end
    ready_d = clint_valid;

    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_tick;
    if (wr) begin
      case (off_w)
        OffMsip:    if (clint_wstrb[0]) msip_d = clint_wdata[0];
        OffCmpLo:   mtimecmp_d[31:0]  = (mtimecmp_q[31:0] & ~wmask) | (clint_wdata & wmask);
        OffCmpHi:   mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (clint_wdata & wmask);
        // A written half merges against the pre-tick value; the other half keeps the tick.
        OffMtimeLo: mtime_d[31:0]  = (mtime_q[31:0] & ~wmask) | (clint_wdata & wmask);
        OffMtimeHi: mtime_d[63:32] = (mtime_q[63:32] & ~wmask) | (clint_wdata & wmask);
        default:    ;
      endcase
    end

    mtip_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q      <= 32'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      div_q      <= div_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
    end
  end

  assign clint_rdata = rdata_q;
  assign clint_ready = ready_q;
  assign clint_msip  = msip_q;
  assign clint_mtip  = mtip_q;
  assign clint_mtime = mtime_q;

endmodule

// File: tb/tb_clint_responder.sv
// Self-checking bench for clint_responder, run with a divider of 3 so mtime ticks every 4 clocks.
// A cycle-level reference model tracks registers from clocks elapsed since reset release.
module tb_clint_responder;

  localparam int unsigned Div = 3;
  localparam logic [31:0] Base = 32'h0200_0000;
  localparam logic [31:0] Top  = 32'h0200_C000;

  logic        clock, reset;
  logic        clint_valid, clint_instr;
  logic [31:0] clint_addr, clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready, clint_msip, clint_mtip;
  logic [63:0] clint_mtime;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, m_ready;
  logic [31:0] m_rdata;
  longint unsigned m_cyc;

  clint_responder #(
    .clint_base_addr(Base),
    .clint_top_addr (Top),
    .clk_divider_rtc(Div)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clint_valid(clint_valid),
    .clint_instr(clint_instr),
    .clint_addr (clint_addr),
    .clint_wdata(clint_wdata),
    .clint_wstrb(clint_wstrb),
    .clint_rdata(clint_rdata),
    .clint_ready(clint_ready),
    .clint_msip (clint_msip),
    .clint_mtip (clint_mtip),
    .clint_mtime(clint_mtime)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Apply one bus cycle, advance the model, return at posedge+1.
  task automatic step(input logic v, input logic i, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    logic [63:0] n_mtime, n_cmp;
    logic        n_msip, n_mtip, hit;
    logic [31:0] n_rdata, off;
    clint_valid = v; clint_instr = i; clint_addr = a; clint_wdata = d; clint_wstrb = s;
    n_mtime = ((m_cyc % (Div + 1)) == Div) ? m_mtime + 64'd1 : m_mtime;
    n_cmp   = m_cmp;
    n_msip  = m_msip;
    n_mtip  = (m_mtime >= m_cmp);
    hit     = v && !i && (a >= Base) && (a < Top);
    off     = (a - Base) & ~32'h3;
    n_rdata = 32'd0;
    if (hit) begin
      if (off == 32'h0)    n_rdata = {31'd0, m_msip};
      if (off == 32'h4000) n_rdata = m_cmp[31:0];
      if (off == 32'h4004) n_rdata = m_cmp[63:32];
      if (off == 32'hBFF8) n_rdata = m_mtime[31:0];
      if (off == 32'hBFFC) n_rdata = m_mtime[63:32];
      if (s != 4'b0) begin
        if (off == 32'h0 && s[0]) n_msip = d[0];
        if (off == 32'h4000) n_cmp[31:0]    = merge(m_cmp[31:0], d, s);
        if (off == 32'h4004) n_cmp[63:32]   = merge(m_cmp[63:32], d, s);
        if (off == 32'hBFF8) n_mtime[31:0]  = merge(m_mtime[31:0], d, s);
        if (off == 32'hBFFC) n_mtime[63:32] = merge(m_mtime[63:32], d, s);
      end
    end
    @(posedge clock);
    #1;
    m_mtime = n_mtime; m_cmp = n_cmp; m_msip = n_msip; m_mtip = n_mtip;
    m_ready = v; m_rdata = n_rdata; m_cyc++;
    clint_valid = 1'b0; clint_instr = 1'b0; clint_wstrb = 4'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    m_mtime = 64'd0; m_cmp = '1; m_msip = 1'b0; m_mtip = 1'b0;
    m_ready = 1'b0; m_rdata = 32'd0; m_cyc = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({clint_ready, clint_rdata, clint_msip, clint_mtip, clint_mtime} !== 99'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%0b rdata=%h msip=%0b mtip=%0b mtime=%h want all 0",
               clint_ready, clint_rdata, clint_msip, clint_mtip, clint_mtime);
    end
    do_reset();
    step(1'b1, 1'b0, 32'h0200_4000, 32'd0, 4'd0);
    checks++;
    if (clint_ready !== 1'b1 || clint_rdata !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mtimecmp_read: got ready=%0b rdata=%h want 1 ffffffff",
               clint_ready, clint_rdata);
    end
  endtask

  task automatic test_msip();
    step(1'b1, 1'b0, 32'h0200_0000, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (clint_ready !== 1'b1 || clint_msip !== 1'b1) begin
      errors++;
      $display("FAIL msip_set: got ready=%0b msip=%0b want 1 1", clint_ready, clint_msip);
    end
    step(1'b1, 1'b0, 32'h0200_0000, 32'd0, 4'd0);
    checks++;
    if (clint_rdata !== 32'h1) begin
      errors++;
      $display("FAIL msip_read: got %h want 00000001", clint_rdata);
    end
    step(1'b1, 1'b0, 32'h0200_0000, 32'd0, 4'hF);
    checks++;
    if (clint_msip !== 1'b0) begin
      errors++;
      $display("FAIL msip_clear: got %0b want 0", clint_msip);
    end
  endtask

  task automatic test_mtime_advance();
    do_reset();
    idle(39);
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'd0, 4'd0);
    checks++;
    if (clint_mtime !== 64'd10 || clint_mtime !== m_mtime) begin
      errors++;
      $display("FAIL mtime_after_40: got %0d want 10", clint_mtime);
    end
    checks++;
    if (clint_rdata !== 32'd9 || clint_rdata !== m_rdata) begin
      errors++;
      $display("FAIL mtime_read_pretick: got %0d want 9", clint_rdata);
    end
  endtask

  task automatic test_timer_irq();
    bit seen = 0;
    do_reset();
    step(1'b1, 1'b0, 32'h0200_4004, 32'd0, 4'hF);
    step(1'b1, 1'b0, 32'h0200_4000, 32'd5, 4'hF);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      checks++;
      if (clint_mtip !== m_mtip) begin
        errors++;
        $display("FAIL mtip_track: cycle %0d mtime=%0d got %0b want %0b",
                 k, clint_mtime, clint_mtip, m_mtip);
      end
      if (m_mtip) seen = 1;
    end
    checks++;
    if (!seen || clint_mtip !== 1'b1) begin
      errors++;
      $display("FAIL mtip_rise: got %0b want 1", clint_mtip);
    end
    step(1'b1, 1'b0, 32'h0200_4000, 32'h100, 4'hF);
    checks++;
    if (clint_mtip !== 1'b1) begin
      errors++;
      $display("FAIL mtip_lag: got %0b want 1", clint_mtip);
    end
    idle(1);
    checks++;
    if (clint_mtip !== 1'b0) begin
      errors++;
      $display("FAIL mtip_clear: got %0b want 0", clint_mtip);
    end
  endtask

  task automatic test_wrap_collision();
    step(1'b1, 1'b0, 32'h0200_BFFC, 32'd0, 4'hF);
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    idle(4);
    checks++;
    if (clint_mtime !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL mtime_wrap: got %h want 0000000100000000", clint_mtime);
    end
    for (int k = 0; k < 8 && (m_cyc % (Div + 1)) != Div; k++) idle(1);
    step(1'b1, 1'b0, 32'h0200_BFF8, 32'h0000_00AA, 4'h1);
    checks++;
    if (clint_mtime !== 64'h1_0000_00AA || clint_mtime !== m_mtime) begin
      errors++;
      $display("FAIL mtime_collision: got %h want 00000001000000aa", clint_mtime);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 32'h0200_0000, 32'd0, 4'd0);
    checks++;
    if (clint_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready0: got %0b want 1", clint_ready);
    end
    step(1'b1, 1'b0, 32'h0200_4004, 32'h1234_5678, 4'hF);
    checks++;
    if (clint_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready1: got %0b want 1", clint_ready);
    end
    step(1'b1, 1'b0, 32'h0200_4006, 32'd0, 4'd0);
    checks++;
    if (clint_ready !== 1'b1 || clint_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_read: got ready=%0b rdata=%h want 1 12345678", clint_ready, clint_rdata);
    end
    idle(1);
    checks++;
    if (clint_ready !== 1'b0 || clint_rdata !== 32'd0) begin
      errors++;
      $display("FAIL b2b_idle: got ready=%0b rdata=%h want 0 0", clint_ready, clint_rdata);
    end
  endtask

  task automatic test_corner();
    step(1'b1, 1'b0, 32'h0200_0000, 32'd1, 4'h1);
    step(1'b1, 1'b0, 32'h0200_1000, 32'd0, 4'd0);
    checks++;
    if (clint_ready !== 1'b1 || clint_rdata !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read: got ready=%0b rdata=%h want 1 0", clint_ready, clint_rdata);
    end
    step(1'b1, 1'b1, 32'h0200_0000, 32'd0, 4'hF);
    checks++;
    if (clint_ready !== 1'b1 || clint_rdata !== 32'd0 || clint_msip !== 1'b1) begin
      errors++;
      $display("FAIL instr_write: got ready=%0b rdata=%h msip=%0b want 1 0 1",
               clint_ready, clint_rdata, clint_msip);
    end
    // Reset arriving while a response is pending drops it.
    step(1'b1, 1'b0, 32'h0200_4000, 32'd0, 4'd0);
    reset = 1'b1;
    #1;
    checks++;
    if (clint_ready !== 1'b0 || clint_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_midreq: got ready=%0b rdata=%h want 0 0", clint_ready, clint_rdata);
    end
    do_reset();
    idle(1);
    checks++;
    if (clint_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %0b want 0", clint_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        v, i;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 8))
        0:       a = 32'h0200_0000;
        1:       a = 32'h0200_4000;
        2:       a = 32'h0200_4004;
        3:       a = 32'h0200_BFF8;
        4:       a = 32'h0200_BFFC;
        5:       a = 32'h0200_0000 + ($urandom_range(0, 32'hBFFF) & ~32'h3);
        6:       a = 32'h0200_C000 + $urandom_range(0, 255);
        7:       a = 32'h0200_4000 | $urandom_range(0, 3);
        default: a = 32'h0200_BFF8 | $urandom_range(0, 7);
      endcase
      d = $urandom;
      // Keep mtime/mtimecmp high halves small so mtip toggles both ways.
      if (a[15:0] == 16'h4004 || a[15:0] == 16'hBFFC) d = {30'd0, d[1:0]};
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      v = ($urandom_range(0, 9) < 7);
      i = ($urandom_range(0, 9) == 0);
      step(v, i, a, d, s);
      checks++;
      if (clint_ready !== m_ready || clint_msip !== m_msip || clint_mtip !== m_mtip ||
          clint_mtime !== m_mtime) begin
        errors++;
        $display("FAIL rand_state %0d: got rdy=%0b msip=%0b mtip=%0b mtime=%h want %0b %0b %0b %h",
                 k, clint_ready, clint_msip, clint_mtip, clint_mtime,
                 m_ready, m_msip, m_mtip, m_mtime);
      end
      if (v && (i || s == 4'd0)) begin
        checks++;
        if (clint_rdata !== m_rdata) begin
          errors++;
          $display("FAIL rand_rdata %0d addr=%h: got %h want %h", k, a, clint_rdata, m_rdata);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clint_valid = 1'b0; clint_instr = 1'b0; clint_addr = 32'd0;
    clint_wdata = 32'd0; clint_wstrb = 4'd0;
    m_cyc = 0;
    test_reset();
    test_msip();
    test_mtime_advance();
    test_timer_irq();
    test_wrap_collision();
    test_back_to_back();
    test_corner();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
